// File: rtl/branch_ctrl.sv
// Branch resolution and misprediction recovery: a 2-bit saturating-counter predictor,
// condition evaluation against ALU flags, and a fixed-length flush/stall window.
module branch_ctrl #(
    parameter int PC_W         = 16,
    parameter int IDX_W        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [PC_W-1:0] res_pc,
    input  logic [2:0]      res_cond,
    input  logic            res_z,
    input  logic            res_ov,
    input  logic            res_n,
    input  logic            res_pred,
    input  logic [PC_W-1:0] res_target,
    output logic            flush,
    output logic            stall,
    output logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     miss_count
);

    typedef enum logic {IDLE, RECOVER} state_t;

    localparam int          ENTRIES  = 2 ** IDX_W;
    localparam logic [3:0]  CNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [2:0]  COND_ALWAYS = 3'd7;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic cond_act(input logic [2:0] c, input logic z, input logic n,
                                      input logic ov);
        case (c)
            3'd0:    return z;
            3'd1:    return ~(z | n);
            3'd2:    return ~n;
            3'd3:    return n;
            3'd4:    return z | n;
            3'd5:    return ~z;
            3'd6:    return ov;
            default: return 1'b1;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic [PC_W-1:0] redirect_q, redirect_d;
    logic [15:0]     count_q, count_d;
    logic [1:0]      ctr_q [ENTRIES];

    logic [IDX_W-1:0] res_idx;
    logic             act;
    logic             miss;
    logic             upd_en;
    logic [1:0]       upd_val;
    logic             unused_pred_pc_hi;

    // Prediction is a raw read of the pre-update table contents.
    assign pred_taken        = ctr_q[pred_pc[IDX_W-1:0]][1];
    assign unused_pred_pc_hi = ^pred_pc[PC_W-1:IDX_W];

    assign res_idx = res_pc[IDX_W-1:0];
    assign act     = cond_act(res_cond, res_z, res_n, res_ov);
    assign miss    = act ^ res_pred;
    assign upd_val = act ? sat_inc2(ctr_q[res_idx]) : sat_dec2(ctr_q[res_idx]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        count_d    = count_q;
        upd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    upd_en = (res_cond != COND_ALWAYS);
                    if (miss) begin
                        flush_d    = 1'b1;
                        redirect_d = act ? res_target : res_pc + PC_W'(1);
                        count_d    = sat_inc16(count_q);
                        cnt_d      = CNT_INIT;
                        state_d    = RECOVER;
                    end
                end
            end
            RECOVER: begin
                // Resolves arriving here are wrong-path and are dropped.
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            count_q    <= 16'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            count_q    <= count_d;
            if (upd_en) begin
                ctr_q[res_idx] <= upd_val;
            end
        end
    end

    assign flush       = flush_q;
    assign stall       = (state_q == RECOVER);
    assign redirect_pc = redirect_q;
    assign miss_count  = count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a behavioural model predicts each cycle's outputs,
// queues them when stimulus is driven, and compares them after the clock edge.
module tb_branch_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [15:0] res_pc;
    logic [2:0]  res_cond;
    logic        res_z, res_ov, res_n, res_pred;
    logic [15:0] res_target;
    logic        flush, stall;
    logic [15:0] redirect_pc;
    logic [15:0] miss_count;

    branch_ctrl #(.PC_W(16), .IDX_W(4), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_cond(res_cond),
        .res_z(res_z), .res_ov(res_ov), .res_n(res_n), .res_pred(res_pred),
        .res_target(res_target), .flush(flush), .stall(stall),
        .redirect_pc(redirect_pc), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        stall;
        logic [15:0] redir;
        logic [15:0] count;
        logic        ptk;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  m_tab[16];
    int          m_stall;
    logic [15:0] m_redir;
    logic [15:0] m_count;
    int          total = 0;
    int          bad = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = 2'b01;
        m_stall = 0;
        m_redir = 16'h0000;
        m_count = 16'h0000;
    endtask

    // One clock of stimulus: checks the pre-update prediction, then the post-edge outputs.
    task automatic step(input logic v, input logic [2:0] c, input logic z, input logic n,
                        input logic ov, input logic p, input logic [15:0] pc,
                        input logic [15:0] tgt, input string nm);
        logic a, acc, mis;
        logic [3:0] idx;
        exp_t e, got;
        @(negedge clk);
        res_valid = v; res_cond = c; res_z = z; res_n = n; res_ov = ov;
        res_pred = p; res_pc = pc; res_target = tgt; pred_pc = pc;
        idx = pc[3:0];
        #1;
        total++;
        if (pred_taken !== m_tab[idx][1]) begin
            bad++;
            $display("FAIL %s pre_pred got=%b exp=%b", nm, pred_taken, m_tab[idx][1]);
        end
        case (c)
            3'd0: a = z;
            3'd1: a = !z && !n;
            3'd2: a = !n;
            3'd3: a = n;
            3'd4: a = z || n;
            3'd5: a = !z;
            3'd6: a = ov;
            default: a = 1'b1;
        endcase
        acc = v && (m_stall == 0);
        mis = (a != p);
        if (acc && c != 3'd7) begin
            if (a) m_tab[idx] = (m_tab[idx] == 2'd3) ? 2'd3 : m_tab[idx] + 2'd1;
            else   m_tab[idx] = (m_tab[idx] == 2'd0) ? 2'd0 : m_tab[idx] - 2'd1;
        end
        if (acc && mis) begin
            m_stall = FC;
            m_redir = a ? tgt : pc + 16'd1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            e.flush = 1'b1;
        end else begin
            if (m_stall > 0) m_stall = m_stall - 1;
            e.flush = 1'b0;
        end
        e.stall = (m_stall > 0);
        e.redir = m_redir;
        e.count = m_count;
        e.ptk   = m_tab[idx][1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        got = sb.pop_front();
        total += 5;
        if (flush !== got.flush) begin
            bad++; $display("FAIL %s flush got=%b exp=%b", nm, flush, got.flush);
        end
        if (stall !== got.stall) begin
            bad++; $display("FAIL %s stall got=%b exp=%b", nm, stall, got.stall);
        end
        if (redirect_pc !== got.redir) begin
            bad++; $display("FAIL %s redirect got=%h exp=%h", nm, redirect_pc, got.redir);
        end
        if (miss_count !== got.count) begin
            bad++; $display("FAIL %s miss_count got=%h exp=%h", nm, miss_count, got.count);
        end
        if (pred_taken !== got.ptk) begin
            bad++; $display("FAIL %s post_pred got=%b exp=%b", nm, pred_taken, got.ptk);
        end
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pred_pc = 16'(i);
            #1;
            total++;
            if (pred_taken !== 1'b0) begin
                bad++; $display("FAIL reset_pred idx=%0d got=%b exp=0", i, pred_taken);
            end
        end
        total++;
        if ({flush, stall, redirect_pc, miss_count} !== 34'd0) begin
            bad++;
            $display("FAIL reset_outputs got flush=%b stall=%b redir=%h cnt=%h exp all 0",
                     flush, stall, redirect_pc, miss_count);
        end
    endtask

    task automatic test_miss_eq();
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0200, "miss_eq");
        idle(3, "miss_eq_recover");
    endtask

    task automatic test_counter_sat();
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0023, 16'h0400, "gr_taken");
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0023, 16'h0400, "gr_not_taken");
    endtask

    task automatic test_back_to_back();
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0031, 16'h0100, "b2b_greq");
        step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0032, 16'h0100, "b2b_le");
        step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0033, 16'h0100, "b2b_leeq");
        step(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0034, 16'h0100, "b2b_ov");
        step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0035, 16'h0777, "ov_miss");
        idle(2, "ov_miss_recover");
    endtask

    task automatic test_wrong_path();
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0abc, "wp_miss");
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0def, "wp_ignored1");
        step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0fed, "wp_ignored2");
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0041, 16'h0123, "wp_first_accept");
    endtask

    task automatic test_wrap_always();
        step(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h1234, "neq_wrap");
        idle(2, "neq_wrap_recover");
        step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h5555, "always_hit");
        step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h6666, "always_miss");
        idle(2, "always_recover");
    endtask

    task automatic test_reset_recover();
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0300, "rr_miss");
        idle(1, "rr_stall1");
        do_reset();
        total++;
        if ({flush, stall, redirect_pc, miss_count} !== 34'd0) begin
            bad++;
            $display("FAIL reset_mid_recover got flush=%b stall=%b redir=%h cnt=%h exp all 0",
                     flush, stall, redirect_pc, miss_count);
        end
        step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0300, "rr_after_reset");
    endtask

    task automatic test_count_sat();
        @(negedge clk);
        force dut.count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.count_q;
        m_count = 16'hFFFE;
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0900, "cnt_to_max");
        idle(2, "cnt_recover1");
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0a00, "cnt_saturated");
        idle(2, "cnt_recover2");
    endtask

    initial begin
        rst = 1'b1; res_valid = 1'b0; pred_pc = '0; res_pc = '0; res_cond = '0;
        res_z = 1'b0; res_ov = 1'b0; res_n = 1'b0; res_pred = 1'b0; res_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_miss_eq();
        test_counter_sat();
        test_back_to_back();
        test_wrong_path();
        test_wrap_always();
        test_reset_recover();
        test_count_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
